// File: rtl/alu_link_pkg.sv
// Shared definitions for the UART ALU byte link: widths, initiator states and opcodes
// understood by the ALU interface FSM.
package alu_link_pkg;

  localparam int unsigned NB_DATA = 8;
  localparam int unsigned NB_OP   = 6;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFlush   = 3'd1,
    StSendOp  = 3'd2,
    StSendA   = 3'd3,
    StSendB   = 3'd4,
    StWaitRes = 3'd5,
    StDone    = 3'd6
  } state_e;

  localparam logic [NB_OP-1:0] OpAdd = 6'h20;
  localparam logic [NB_OP-1:0] OpSub = 6'h22;
  localparam logic [NB_OP-1:0] OpAnd = 6'h24;
  localparam logic [NB_OP-1:0] OpOr  = 6'h25;
  localparam logic [NB_OP-1:0] OpXor = 6'h26;
  localparam logic [NB_OP-1:0] OpNor = 6'h27;
  localparam logic [NB_OP-1:0] OpSra = 6'h03;
  localparam logic [NB_OP-1:0] OpSrl = 6'h02;

endpackage

// File: rtl/alu_cmd_initiator_wait_timer.sv
// Saturating wait counter: clear/enable, flags when the count reaches LIMIT-1.
module wait_timer #(
  parameter int unsigned LIMIT = 1000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(LIMIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_cmd_initiator.sv
// Link initiator: flushes stale RX bytes, sends opcode/A/B to the TX FIFO, then waits
// (bounded) for the single result byte from the RX FIFO.
module alu_cmd_initiator
  import alu_link_pkg::*;
#(
  parameter int unsigned NB_DATA        = alu_link_pkg::NB_DATA,
  parameter int unsigned NB_OP          = alu_link_pkg::NB_OP,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_OP-1:0]   i_op,
  input  logic [NB_DATA-1:0] i_data_a,
  input  logic [NB_DATA-1:0] i_data_b,
  input  logic               i_tx_full,
  output logic               o_tx_write,
  output logic [NB_DATA-1:0] o_tx_writedata,
  input  logic               i_rx_empty,
  input  logic [NB_DATA-1:0] i_rx_readdata,
  output logic               o_rx_read,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_done,
  output logic               o_timeout,
  output logic               o_busy,
  output logic [2:0]         o_state
);

  state_e             state_q, state_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] a_q, a_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic [NB_DATA-1:0] result_q, result_d;
  logic               done_q, timeout_q, timeout_d, busy_q;
  logic               wait_first_q;
  logic               expired;

  // The counter is cleared during the first WAIT_RES cycle, so the limit is hit
  // TIMEOUT_CYCLES cycles after entry and DONE follows one cycle later.
  wait_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .clear_i  ((state_q != StWaitRes) || wait_first_q),
    .en_i     (i_rx_empty),
    .expired_o(expired)
  );

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    result_d       = result_q;
    timeout_d      = timeout_q;
    o_tx_write     = 1'b0;
    o_tx_writedata = '0;
    o_rx_read      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          op_d      = i_op;
          a_d       = i_data_a;
          b_d       = i_data_b;
          timeout_d = 1'b0;
          state_d   = StFlush;
        end
      end
      StFlush: begin
        o_rx_read = ~i_rx_empty;
        if (i_rx_empty) state_d = StSendOp;
      end
      StSendOp: begin
        o_tx_write     = ~i_tx_full;
        o_tx_writedata = NB_DATA'(op_q);
        if (!i_tx_full) state_d = StSendA;
      end
      StSendA: begin
        o_tx_write     = ~i_tx_full;
        o_tx_writedata = a_q;
        if (!i_tx_full) state_d = StSendB;
      end
      StSendB: begin
        o_tx_write     = ~i_tx_full;
        o_tx_writedata = b_q;
        if (!i_tx_full) state_d = StWaitRes;
      end
      StWaitRes: begin
        o_rx_read = ~i_rx_empty;
        // A byte present on the limit cycle takes priority over the timeout.
        if (!i_rx_empty) begin
          result_d = i_rx_readdata;
          state_d  = StDone;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= StIdle;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
      wait_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      done_q       <= (state_d == StDone);
      timeout_q    <= timeout_d;
      busy_q       <= (state_d != StIdle);
      wait_first_q <= (state_d == StWaitRes) && (state_q != StWaitRes);
    end
  end

  assign o_result  = result_q;
  assign o_done    = done_q;
  assign o_timeout = timeout_q;
  assign o_busy    = busy_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_alu_cmd_initiator.sv
// Scoreboard bench for alu_cmd_initiator: expected TX bytes and completions are queued
// at stimulus time and compared as the DUT pushes bytes and pulses o_done.
module tb_alu_cmd_initiator;

  localparam int unsigned TimeoutCycles = 16;

  logic       i_clk = 1'b0;
  logic       i_reset, i_start, i_tx_full, i_rx_empty;
  logic [5:0] i_op;
  logic [7:0] i_data_a, i_data_b, i_rx_readdata;
  logic       o_tx_write, o_rx_read, o_done, o_timeout, o_busy;
  logic [7:0] o_tx_writedata, o_result;
  logic [2:0] o_state;

  typedef struct {
    logic [7:0] res;
    logic       to;
    int         cyc;
  } done_exp_t;

  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_q[$];
  done_exp_t  done_exp_q[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic done_seen = 1'b0;
  logic done_prev = 1'b0;

  alu_cmd_initiator #(
    .NB_DATA       (8),
    .NB_OP         (6),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_op          (i_op),
    .i_data_a      (i_data_a),
    .i_data_b      (i_data_b),
    .i_tx_full     (i_tx_full),
    .o_tx_write    (o_tx_write),
    .o_tx_writedata(o_tx_writedata),
    .i_rx_empty    (i_rx_empty),
    .i_rx_readdata (i_rx_readdata),
    .o_rx_read     (o_rx_read),
    .o_result      (o_result),
    .o_done        (o_done),
    .o_timeout     (o_timeout),
    .o_busy        (o_busy),
    .o_state       (o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic rx_refresh();
    i_rx_empty    = (rx_q.size() == 0);
    i_rx_readdata = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
  endtask

  // Monitor at the falling edge, then advance one clock; RX pops land after the edge.
  task automatic tick();
    logic      pop;
    done_exp_t e;
    @(negedge i_clk);
    pop = o_rx_read;
    if (o_rx_read) check_eq("rx_pop_nonempty", 32'(i_rx_empty), 32'd0);
    if (i_tx_full) check_eq("no_push_when_full", 32'(o_tx_write), 32'd0);
    if (o_tx_write) begin
      check_eq("tx_push_expected", 32'(tx_exp_q.size() != 0), 32'd1);
      if (tx_exp_q.size() != 0) check_eq("tx_byte", 32'(o_tx_writedata), 32'(tx_exp_q.pop_front()));
    end
    if (done_prev) check_eq("done_one_cycle", 32'(o_done), 32'd0);
    done_prev = o_done;
    if (o_done) begin
      done_seen = 1'b1;
      check_eq("done_expected", 32'(done_exp_q.size() != 0), 32'd1);
      if (done_exp_q.size() != 0) begin
        e = done_exp_q.pop_front();
        check_eq("result", 32'(o_result), 32'(e.res));
        check_eq("timeout_flag", 32'(o_timeout), 32'(e.to));
        check_eq("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    @(posedge i_clk);
    #1;
    cyc++;
    if (pop && rx_q.size() != 0) void'(rx_q.pop_front());
    rx_refresh();
  endtask

  // Offsets are in cycles relative to the start cycle (c0); negative disables a feature.
  task automatic run_txn(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int full_from, input int full_len, input int inj_at,
                         input logic [7:0] inj_byte, input int spur_at, input int done_off,
                         input logic [7:0] exp_res, input logic exp_to);
    int s;
    s = cyc;
    tx_exp_q.push_back(8'(op));
    tx_exp_q.push_back(a);
    tx_exp_q.push_back(b);
    done_exp_q.push_back('{res: exp_res, to: exp_to, cyc: s + done_off});
    done_seen = 1'b0;
    i_op = op; i_data_a = a; i_data_b = b; i_start = 1'b1;
    for (int k = 0; k < done_off + 4 && !done_seen; k++) begin
      tick();
      i_start = (spur_at >= 0) && (cyc == s + spur_at);
      if (i_start) begin
        i_op = 6'h3f; i_data_a = 8'hee; i_data_b = 8'hdd;
      end
      i_tx_full = (full_len > 0) && (cyc >= s + full_from) && (cyc < s + full_from + full_len);
      if (inj_at >= 0 && cyc == s + inj_at) begin
        rx_q.push_back(inj_byte);
        rx_refresh();
      end
    end
    i_start = 1'b0;
    i_tx_full = 1'b0;
    check_eq("done_seen", 32'(done_seen), 32'd1);
    check_eq("tx_all_pushed", 32'(tx_exp_q.size()), 32'd0);
    tx_exp_q.delete();
    done_exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    i_reset = 1'b1; i_start = 1'b0; i_tx_full = 1'b0;
    i_op = '0; i_data_a = '0; i_data_b = '0;
    rx_refresh();
    repeat (3) tick();
    i_reset = 1'b0;
    check_eq("rst_tx_write", 32'(o_tx_write), 32'd0);
    check_eq("rst_tx_writedata", 32'(o_tx_writedata), 32'd0);
    check_eq("rst_rx_read", 32'(o_rx_read), 32'd0);
    check_eq("rst_result", 32'(o_result), 32'd0);
    check_eq("rst_done", 32'(o_done), 32'd0);
    check_eq("rst_timeout", 32'(o_timeout), 32'd0);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_state", 32'(o_state), 32'd0);
    tick();

    // Best case: pushes at c2..c4, result injected at c5, done at c6.
    run_txn(6'h20, 8'h05, 8'h03, -1, 0, 5, 8'h08, -1, 6, 8'h08, 1'b0);
    tick();

    // Two stale bytes flushed in c1/c2, sends at c4..c6, result at c7.
    rx_q.push_back(8'haa);
    rx_q.push_back(8'hbb);
    rx_refresh();
    run_txn(6'h22, 8'h09, 8'h04, -1, 0, 7, 8'h05, -1, 8, 8'h05, 1'b0);
    check_eq("stale_flushed", 32'(rx_q.size()), 32'd0);
    tick();

    // TX full for 10 cycles in SEND_A: A goes out at c13, B at c14, result at c15.
    run_txn(6'h24, 8'hf0, 8'h3c, 3, 10, 15, 8'h30, -1, 16, 8'h30, 1'b0);
    tick();

    // No response: WAIT_RES entered at c5, done at c5+17, previous result kept.
    run_txn(6'h25, 8'h11, 8'h22, -1, 0, -1, 8'h00, -1, 22, 8'h30, 1'b1);
    repeat (3) tick();
    check_eq("timeout_sticky", 32'(o_timeout), 32'd1);
    check_eq("result_kept", 32'(o_result), 32'h30);
    check_eq("idle_after_timeout", 32'(o_busy), 32'd0);

    // Result on the limit cycle wins; spurious start at c3 is ignored; timeout cleared.
    run_txn(6'h26, 8'h0f, 8'h70, -1, 0, 21, 8'h77, 3, 22, 8'h77, 1'b0);
    repeat (3) tick();
    check_eq("spur_ignored_busy", 32'(o_busy), 32'd0);
    check_eq("spur_ignored_state", 32'(o_state), 32'd0);

    // Reset while in SEND_B: B is still pushed that cycle, then everything returns to reset.
    s = cyc;
    tx_exp_q.push_back(8'h27);
    tx_exp_q.push_back(8'h12);
    tx_exp_q.push_back(8'h34);
    i_op = 6'h27; i_data_a = 8'h12; i_data_b = 8'h34; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    while (cyc < s + 4) tick();
    check_eq("in_send_b", 32'(o_state), 32'd4);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check_eq("mid_rst_tx_write", 32'(o_tx_write), 32'd0);
    check_eq("mid_rst_tx_writedata", 32'(o_tx_writedata), 32'd0);
    check_eq("mid_rst_rx_read", 32'(o_rx_read), 32'd0);
    check_eq("mid_rst_result", 32'(o_result), 32'd0);
    check_eq("mid_rst_done", 32'(o_done), 32'd0);
    check_eq("mid_rst_timeout", 32'(o_timeout), 32'd0);
    check_eq("mid_rst_busy", 32'(o_busy), 32'd0);
    check_eq("mid_rst_state", 32'(o_state), 32'd0);
    check_eq("partial_pushed", 32'(tx_exp_q.size()), 32'd0);
    tx_exp_q.delete();
    repeat (2) tick();

    // Recovery after reset: best-case timing again.
    run_txn(6'h02, 8'h80, 8'h01, -1, 0, 5, 8'hc3, -1, 6, 8'hc3, 1'b0);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
